decimating_averager: RTL and testbench

DECIMATING_AVERAGER -- requirements
Module: decimating_averager

---
 rtl/decimating_averager_pkg.sv | 33 +++
 rtl/decimating_averager_channel.sv | 84 ++++++++
 rtl/decimating_averager.sv | 138 +++++++++++++
 tb/tb_decimating_averager.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decimating_averager_pkg.sv
// Shared definitions for the decimating averager: FSM encoding, the width of
// the factor field, and helpers for accumulator sizing and factor clamping.
package decimating_averager_pkg;

    // Control FSM: IDLE discards everything, ACCUM builds averaging blocks.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Width of the runtime log2-factor field on the ports.
    localparam int FACTOR_W = 4;

    // Accumulator width: a full block of 2^max_log2 maximum-value samples
    // fits without wrapping.
    function automatic int acc_width(input int dwidth, input int max_log2);
        return dwidth + max_log2;
    endfunction

    // Limit a requested log2 factor to the largest factor the accumulators
    // were sized for.
    function automatic logic [FACTOR_W-1:0] clamp_log2(
        input logic [FACTOR_W-1:0] req,
        input logic [FACTOR_W-1:0] max_l2
    );
        if (req > max_l2) begin
            return max_l2;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/decimating_averager_channel.sv
// One channel of the decimating averager: accumulates samples, and when the
// top closes a block produces the rounded, shifted and saturated average.
module averager_channel
    import decimating_averager_pkg::*;
#(
    parameter int DWIDTH   = 14,
    parameter int MAX_LOG2 = 8,
    parameter int ROUND    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                acc_clr,
    input  logic                acc_add,
    input  logic                blk_close,
    input  logic [FACTOR_W-1:0] factor,
    input  logic [DWIDTH-1:0]   sample,
    output logic [DWIDTH-1:0]   avg
);

    localparam int ACCW = acc_width(DWIDTH, MAX_LOG2);

    // Largest representable average, extended to the rounding width.
    localparam logic [ACCW:0] MAX_AVG = {{(ACCW + 1 - DWIDTH){1'b0}}, {DWIDTH{1'b1}}};
    localparam logic [ACCW:0] ONE_W   = {{ACCW{1'b0}}, 1'b1};

    logic [ACCW-1:0]   acc_q;
    logic [ACCW-1:0]   acc_d;
    logic [DWIDTH-1:0] avg_q;
    logic [DWIDTH-1:0] avg_d;
    logic [ACCW-1:0]   sum_s;
    logic [ACCW:0]     round_s;
    logic [ACCW:0]     shifted_s;
    logic [DWIDTH-1:0] sat_s;

    // Block sum including the current sample, then round, shift and saturate.
    // One extra bit keeps sum + rounding constant from wrapping.
    always_comb begin
        sum_s = acc_q + {{MAX_LOG2{1'b0}}, sample};
        if ((ROUND != 0) && (factor != 4'd0)) begin
            round_s = ONE_W << (factor - 4'd1);
        end else begin
            round_s = '0;
        end
        shifted_s = ({1'b0, sum_s} + round_s) >> factor;
        if (shifted_s > MAX_AVG) begin
            sat_s = {DWIDTH{1'b1}};
        end else begin
            sat_s = shifted_s[DWIDTH-1:0];
        end
    end

    // Next accumulator and output: clear wins, a closing sample publishes the
    // average and restarts from zero, otherwise the sample is accumulated.
    always_comb begin
        acc_d = acc_q;
        avg_d = avg_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (acc_add) begin
            if (blk_close) begin
                acc_d = '0;
                avg_d = sat_s;
            end else begin
                acc_d = sum_s;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and registered average, cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            avg_q <= '0;
        end else begin
            acc_q <= acc_d;
            avg_q <= avg_d;
        end
    end

    assign avg = avg_q;

endmodule

// File: rtl/decimating_averager.sv
// Multi-channel decimating averager. A shared FSM and sample counter decide
// when a block of 2^FACTOR_ACTIVE valid samples closes; each channel instance
// accumulates its own samples and emits the average one cycle later.
module decimating_averager
    import decimating_averager_pkg::*;
#(
    parameter int DWIDTH   = 14,
    parameter int NCH      = 2,
    parameter int MAX_LOG2 = 8,
    parameter int ROUND    = 1
) (
    input  logic                    CLOCK_IN,
    input  logic                    RESET_N,
    input  logic                    ENABLE,
    input  logic                    CLEAR,
    input  logic [FACTOR_W-1:0]     LOG2_FACTOR,
    input  logic                    IN_VALID,
    input  logic [NCH*DWIDTH-1:0]   DATA_IN,
    output logic                    OUT_VALID,
    output logic [NCH*DWIDTH-1:0]   DATA_OUT,
    output logic [FACTOR_W-1:0]     FACTOR_ACTIVE
);

    localparam logic [FACTOR_W-1:0] MAX_L2_C = FACTOR_W'(MAX_LOG2);
    localparam logic [MAX_LOG2:0]   ONE_T    = {{MAX_LOG2{1'b0}}, 1'b1};
    localparam logic [MAX_LOG2-1:0] ONE_C    = {{(MAX_LOG2 - 1){1'b0}}, 1'b1};

    state_e                state_q;
    state_e                state_d;
    logic [FACTOR_W-1:0]   factor_q;
    logic [FACTOR_W-1:0]   factor_d;
    logic [MAX_LOG2-1:0]   cnt_q;
    logic [MAX_LOG2-1:0]   cnt_d;
    logic                  out_valid_q;
    logic                  out_valid_d;

    logic [FACTOR_W-1:0]   req_factor_s;
    logic [MAX_LOG2:0]     term_s;
    logic                  last_s;
    logic                  acc_clr_s;
    logic                  acc_add_s;
    logic                  close_s;

    // Clamped requested factor and detection of the last sample of a block.
    always_comb begin
        req_factor_s = clamp_log2(LOG2_FACTOR, MAX_L2_C);
        term_s       = (ONE_T << factor_q) - ONE_T;
        last_s       = ({1'b0, cnt_q} == term_s);
    end

    // Next-state and datapath control. The factor is only relatched at a
    // block start (enable, clear or block close), so mid-block changes wait.
    always_comb begin
        state_d     = state_q;
        factor_d    = factor_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        acc_clr_s   = 1'b0;
        acc_add_s   = 1'b0;
        close_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                acc_clr_s = 1'b1;
                if (ENABLE) begin
                    state_d  = ST_ACCUM;
                    factor_d = req_factor_s;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (!ENABLE) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    acc_clr_s = 1'b1;
                end else if (CLEAR) begin
                    cnt_d     = '0;
                    acc_clr_s = 1'b1;
                    factor_d  = req_factor_s;
                end else if (IN_VALID) begin
                    acc_add_s = 1'b1;
                    if (last_s) begin
                        close_s     = 1'b1;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        factor_d    = req_factor_s;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                acc_clr_s = 1'b1;
            end
        endcase
    end

    // State, factor, counter and output-valid registers.
    always_ff @(posedge CLOCK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            factor_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            factor_q    <= factor_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        averager_channel #(
            .DWIDTH   (DWIDTH),
            .MAX_LOG2 (MAX_LOG2),
            .ROUND    (ROUND)
        ) u_ch (
            .clk       (CLOCK_IN),
            .rst_n     (RESET_N),
            .acc_clr   (acc_clr_s),
            .acc_add   (acc_add_s),
            .blk_close (close_s),
            .factor    (factor_q),
            .sample    (DATA_IN[c*DWIDTH +: DWIDTH]),
            .avg       (DATA_OUT[c*DWIDTH +: DWIDTH])
        );
    end

    assign OUT_VALID     = out_valid_q;
    assign FACTOR_ACTIVE = factor_q;

endmodule

// File: tb/tb_decimating_averager.sv
// Self-checking bench for decimating_averager: a rounding and a truncating
// instance share stimulus; a behavioural model feeds a scoreboard queue, a
// constant vector table pins exact outputs, and short sequences cover the
// multi-cycle corner cases.
module tb_decimating_averager;

    localparam int DW  = 14;
    localparam int NCH = 2;
    localparam int ML  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [3:0]        l2f;
    logic              vld;
    logic [NCH*DW-1:0] din;
    logic              ov_r;
    logic              ov_t;
    logic [NCH*DW-1:0] dout_r;
    logic [NCH*DW-1:0] dout_t;
    logic [3:0]        fa_r;
    logic [3:0]        fa_t;

    always #5 clk = ~clk;

    decimating_averager #(.DWIDTH(DW), .NCH(NCH), .MAX_LOG2(ML), .ROUND(1)) u_dut_r (
        .CLOCK_IN(clk), .RESET_N(rst_n), .ENABLE(en), .CLEAR(clr), .LOG2_FACTOR(l2f),
        .IN_VALID(vld), .DATA_IN(din), .OUT_VALID(ov_r), .DATA_OUT(dout_r),
        .FACTOR_ACTIVE(fa_r)
    );

    decimating_averager #(.DWIDTH(DW), .NCH(NCH), .MAX_LOG2(ML), .ROUND(0)) u_dut_t (
        .CLOCK_IN(clk), .RESET_N(rst_n), .ENABLE(en), .CLEAR(clr), .LOG2_FACTOR(l2f),
        .IN_VALID(vld), .DATA_IN(din), .OUT_VALID(ov_t), .DATA_OUT(dout_t),
        .FACTOR_ACTIVE(fa_t)
    );

    typedef struct {
        int r0;
        int r1;
        int t0;
        int t1;
    } exp_t;

    typedef struct {
        logic en;
        logic clr;
        int   l2f;
        logic vld;
        int   d0;
        int   d1;
        logic e_ov;
        int   e_d0;
        int   e_d1;
        int   e_t0;
        int   e_fa;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[16];

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    int m_state  = 0;
    int m_factor = 0;
    int m_cnt    = 0;
    int m_sum0   = 0;
    int m_sum1   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int avg_f(input int sum, input int f, input int rnd);
        int r;
        int v;
        r = (rnd != 0 && f > 0) ? (1 << (f - 1)) : 0;
        v = (sum + r) >> f;
        if (v > 16383) v = 16383;
        return v;
    endfunction

    function automatic int clamp_f(input int v);
        return (v > ML) ? ML : v;
    endfunction

    task automatic model_reset();
        m_state  = 0;
        m_factor = 0;
        m_cnt    = 0;
        m_sum0   = 0;
        m_sum1   = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input logic e, input logic c, input int lf, input logic v,
                        input int a, input int b);
        logic exp_ov;
        exp_t ex;
        en     = e;
        clr    = c;
        l2f    = 4'(lf);
        vld    = v;
        din    = {14'(b), 14'(a)};
        exp_ov = 1'b0;
        if (m_state == 0) begin
            if (e) begin
                m_state  = 1;
                m_factor = clamp_f(lf);
                m_cnt    = 0;
                m_sum0   = 0;
                m_sum1   = 0;
            end
        end else if (!e) begin
            m_state = 0;
            m_cnt   = 0;
            m_sum0  = 0;
            m_sum1  = 0;
        end else if (c) begin
            m_cnt    = 0;
            m_sum0   = 0;
            m_sum1   = 0;
            m_factor = clamp_f(lf);
        end else if (v) begin
            m_sum0 += a;
            m_sum1 += b;
            if (m_cnt == (1 << m_factor) - 1) begin
                ex.r0 = avg_f(m_sum0, m_factor, 1);
                ex.r1 = avg_f(m_sum1, m_factor, 1);
                ex.t0 = avg_f(m_sum0, m_factor, 0);
                ex.t1 = avg_f(m_sum1, m_factor, 0);
                sb_q.push_back(ex);
                exp_ov   = 1'b1;
                m_cnt    = 0;
                m_sum0   = 0;
                m_sum1   = 0;
                m_factor = clamp_f(lf);
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("sb_ov_round", int'(ov_r), int'(exp_ov));
        chk("sb_ov_trunc", int'(ov_t), int'(exp_ov));
        chk("sb_factor", int'(fa_r), m_factor);
        if (ov_r) pulses++;
        if (exp_ov && sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            chk("sb_r_ch0", int'(dout_r[DW-1:0]), ex.r0);
            chk("sb_r_ch1", int'(dout_r[DW+:DW]), ex.r1);
            chk("sb_t_ch0", int'(dout_t[DW-1:0]), ex.t0);
            chk("sb_t_ch1", int'(dout_t[DW+:DW]), ex.t1);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nv;
        int guard;
        logic v;

        // en clr l2f vld d0 d1 | ov d0 d1 t0 fa
        tbl[0]  = '{1'b1, 1'b0,  2, 1'b0,   0,    0, 1'b0, 0,    0, 0, 2};
        tbl[1]  = '{1'b1, 1'b0,  2, 1'b1,   1,   10, 1'b0, 0,    0, 0, 2};
        tbl[2]  = '{1'b1, 1'b0,  2, 1'b1,   2,   20, 1'b0, 0,    0, 0, 2};
        tbl[3]  = '{1'b1, 1'b0,  2, 1'b1,   3,   30, 1'b0, 0,    0, 0, 2};
        tbl[4]  = '{1'b1, 1'b0,  2, 1'b1,   4,   40, 1'b1, 3,   25, 2, 2};
        tbl[5]  = '{1'b1, 1'b1,  0, 1'b0,   0,    0, 1'b0, 3,   25, 2, 0};
        tbl[6]  = '{1'b1, 1'b0,  0, 1'b1,   7, 1000, 1'b1, 7, 1000, 7, 0};
        tbl[7]  = '{1'b1, 1'b0,  0, 1'b1,   9,    5, 1'b1, 9,    5, 9, 0};
        tbl[8]  = '{1'b1, 1'b0, 15, 1'b0,   0,    0, 1'b0, 9,    5, 9, 0};
        tbl[9]  = '{1'b1, 1'b1, 15, 1'b0,   0,    0, 1'b0, 9,    5, 9, 8};
        tbl[10] = '{1'b0, 1'b0, 15, 1'b1, 500,  500, 1'b0, 9,    5, 9, 8};
        tbl[11] = '{1'b1, 1'b0,  2, 1'b1, 500,  500, 1'b0, 9,    5, 9, 2};
        tbl[12] = '{1'b1, 1'b0,  2, 1'b1,   8,    8, 1'b0, 9,    5, 9, 2};
        tbl[13] = '{1'b1, 1'b0,  2, 1'b1,   8,    8, 1'b0, 9,    5, 9, 2};
        tbl[14] = '{1'b1, 1'b0,  2, 1'b1,   8,    8, 1'b0, 9,    5, 9, 2};
        tbl[15] = '{1'b1, 1'b0,  2, 1'b1,   8,    8, 1'b1, 8,    8, 8, 2};

        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        l2f   = 4'd0;
        vld   = 1'b0;
        din   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", int'(ov_r), 0);
        chk("rst_dout", int'(dout_r), 0);
        chk("rst_factor", int'(fa_r), 0);
        #2 rst_n = 1'b1;

        // Constant vectors: averaging, pass-through, clamp, idle ignore.
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].clr, tbl[i].l2f, tbl[i].vld, tbl[i].d0, tbl[i].d1);
            chk($sformatf("tbl%0d_ov", i), int'(ov_r), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_d0", i), int'(dout_r[DW-1:0]), tbl[i].e_d0);
            chk($sformatf("tbl%0d_d1", i), int'(dout_r[DW+:DW]), tbl[i].e_d1);
            chk($sformatf("tbl%0d_t0", i), int'(dout_t[DW-1:0]), tbl[i].e_t0);
            chk($sformatf("tbl%0d_fa", i), int'(fa_r), tbl[i].e_fa);
        end

        // Full-scale 256-sample block with random valid gaps.
        step(1'b1, 1'b1, 8, 1'b0, 0, 0);
        pulses = 0;
        nv     = 0;
        guard  = 0;
        while (nv < 256 && guard < 4000) begin
            v = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, 8, v, 16383, 16383);
            if (v) nv++;
            guard++;
        end
        chk("max_valids", nv, 256);
        chk("max_pulses", pulses, 1);
        chk("max_last_ov", int'(ov_r), 1);
        chk("max_d0", int'(dout_r[DW-1:0]), 16383);
        chk("max_d1", int'(dout_r[DW+:DW]), 16383);
        chk("max_t0", int'(dout_t[DW-1:0]), 16383);

        // Factor change 2->3 after sample 2: close at 4, then after 8 more.
        step(1'b1, 1'b1, 2, 1'b0, 0, 0);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, (i <= 2) ? 2 : 3, 1'b1, i * 4, 3);
            if (i == 4) begin
                chk("chg_blk1_ov", int'(ov_r), 1);
                chk("chg_blk1_d0", int'(dout_r[DW-1:0]), 10);
                chk("chg_blk1_fa", int'(fa_r), 3);
            end
            if (i == 12) begin
                chk("chg_blk2_ov", int'(ov_r), 1);
                chk("chg_blk2_d0", int'(dout_r[DW-1:0]), 34);
            end
        end
        chk("chg_pulses", pulses, 2);

        // Clear on the closing sample suppresses the output.
        step(1'b1, 1'b1, 2, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2, 1'b1, 1, 1);
        step(1'b1, 1'b1, 2, 1'b1, 1, 1);
        chk("clr_no_ov", int'(ov_r), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2, 1'b1, 5, 5);
        chk("clr_next_ov", int'(ov_r), 1);
        chk("clr_next_d0", int'(dout_r[DW-1:0]), 5);

        // Asynchronous reset in the middle of a block.
        step(1'b1, 1'b1, 2, 1'b0, 0, 0);
        step(1'b1, 1'b0, 2, 1'b1, 100, 100);
        step(1'b1, 1'b0, 2, 1'b1, 100, 100);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ov", int'(ov_r), 0);
        chk("arst_dout", int'(dout_r), 0);
        chk("arst_factor", int'(fa_r), 0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_dout", int'(dout_r), 0);
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0, 2, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2, 1'b1, 6, 6);
        chk("arst_next_ov", int'(ov_r), 1);
        chk("arst_next_d0", int'(dout_r[DW-1:0]), 6);

        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
